// File: rtl/nasser_hadi_pipe_checker_if.sv
// ---------------------------------------------------------------------------
// nasser_hadi_pipe_checker_if
// Bundle between the pipe checker, the block that starts it, and the logic
// core under test.
//   start            run request into the checker
//   a_o, b_o, c_o    vector from the checker to core inputs A, B, C
//   x_i, y_i         core outputs x, y returned to the checker
//   busy, done       run status
//   pass, err_count  run result (valid while done=1)
//   first_fail_vld,
//   first_fail_vec   first mismatching vector (only with FIRST_FAIL_EN)
// Modports:
//   slave  - checker side
//   master - host/core side
// Optional feature macro: FIRST_FAIL_EN
// ---------------------------------------------------------------------------
interface nasser_hadi_pipe_checker_if #(
  parameter int ERR_W = 8
);
  logic             start;
  logic             a_o;
  logic             b_o;
  logic             c_o;
  logic             x_i;
  logic             y_i;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
`ifdef FIRST_FAIL_EN
  logic             first_fail_vld;
  logic [2:0]       first_fail_vec;

  modport slave (
    input  start, x_i, y_i,
    output a_o, b_o, c_o, busy, done, pass, err_count,
           first_fail_vld, first_fail_vec
  );
  modport master (
    output start, x_i, y_i,
    input  a_o, b_o, c_o, busy, done, pass, err_count,
           first_fail_vld, first_fail_vec
  );
`else
  modport slave (
    input  start, x_i, y_i,
    output a_o, b_o, c_o, busy, done, pass, err_count
  );
  modport master (
    output start, x_i, y_i,
    input  a_o, b_o, c_o, busy, done, pass, err_count
  );
`endif
endinterface

// File: rtl/nasser_hadi_pipe_checker.sv
// ---------------------------------------------------------------------------
// nasser_hadi_pipe_checker
// Self-test engine for the 2-stage pipelined logic core x=(A&B)|~C, y=~C.
// A start pulse runs NUM_PASSES exhaustive sweeps of {A,B,C}. Each core
// response is compared with a golden value that is delayed by LATENCY
// cycles. The checker then reports a saturating mismatch count and pass/fail.
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous reset, active-high
//   bus   nasser_hadi_pipe_checker_if.slave carrying start, a_o/b_o/c_o,
//         x_i/y_i, busy, done, pass, err_count (+ first_fail_* if enabled)
// Optional feature macro: FIRST_FAIL_EN
//   When defined, the checker latches the first mismatching vector of a run.
// ---------------------------------------------------------------------------
module nasser_hadi_pipe_checker #(
  parameter int LATENCY    = 2,
  parameter int NUM_PASSES = 4,
  parameter int ERR_W      = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  nasser_hadi_pipe_checker_if.slave   bus
);

  localparam int NVEC = 8 * NUM_PASSES;
  localparam int VCW  = (NVEC > 1) ? $clog2(NVEC) : 1;
  localparam int DCW  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                      r_state;
  logic [VCW-1:0]              r_vec_cnt;
  logic [DCW-1:0]              r_drn_cnt;
  logic                        r_a;
  logic                        r_b;
  logic                        r_c;
  logic                        r_busy;
  logic                        r_done;
  logic                        r_pass;
  logic [ERR_W-1:0]            r_err;

  // Golden delay line: a valid bit, the expected {x,y} and the vector itself.
  logic [LATENCY-1:0]          r_vld_p;
  logic [LATENCY-1:0][1:0]     r_gold_p;
  logic [LATENCY-1:0][2:0]     r_vec_p;

`ifdef FIRST_FAIL_EN
  logic                        r_ff_vld;
  logic [2:0]                  r_ff_vec;
`endif

  logic [VCW-1:0]              w_vec_nxt;
  logic                        w_mis;
  logic [ERR_W-1:0]            w_err_nxt;
  logic                        w_push_vld;
  logic [1:0]                  w_push_gold;

  // Golden model of the core: returns {x_exp, y_exp}.
  function automatic logic [1:0] golden(input logic a, input logic b, input logic c);
    return {(a & b) | ~c, ~c};
  endfunction

  // The counter stops at all-ones instead of wrapping.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  assign w_vec_nxt   = r_vec_cnt + VCW'(1);
  // The vector currently on a_o/b_o/c_o is pushed into the line on the edge
  // that ends the cycle in which it was issued. After LATENCY edges it
  // reaches the last stage, where it lines up with the core's response.
  assign w_push_vld  = (r_state == S_RUN);
  assign w_push_gold = golden(r_a, r_b, r_c);

  assign w_mis     = r_vld_p[LATENCY-1] &
                     ((bus.x_i != r_gold_p[LATENCY-1][1]) |
                      (bus.y_i != r_gold_p[LATENCY-1][0]));
  assign w_err_nxt = w_mis ? sat_inc(r_err) : r_err;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_vec_cnt <= '0;
      r_drn_cnt <= '0;
      r_a       <= 1'b0;
      r_b       <= 1'b0;
      r_c       <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_vld_p   <= '0;
      r_gold_p  <= '0;
      r_vec_p   <= '0;
`ifdef FIRST_FAIL_EN
      r_ff_vld  <= 1'b0;
      r_ff_vec  <= 3'b000;
`endif
    end else begin
      // ---- stage boundary: issued vector -> delay line ----
      for (int i = LATENCY - 1; i > 0; i--) begin
        r_vld_p[i]  <= r_vld_p[i-1];
        r_gold_p[i] <= r_gold_p[i-1];
        r_vec_p[i]  <= r_vec_p[i-1];
      end
      r_vld_p[0]  <= w_push_vld;
      r_gold_p[0] <= w_push_gold;
      r_vec_p[0]  <= {r_a, r_b, r_c};

      // ---- stage boundary: delay line tail -> compare/result ----
      // The tail is empty in IDLE and DONE, so these updates only take effect
      // in RUN and DRAIN. A restart below overrides them with clears.
      r_err <= w_err_nxt;
`ifdef FIRST_FAIL_EN
      if (w_mis && !r_ff_vld) begin
        r_ff_vld <= 1'b1;
        r_ff_vec <= r_vec_p[LATENCY-1];
      end
`endif

      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (bus.start) begin
            r_state   <= S_RUN;
            r_vec_cnt <= '0;
            r_drn_cnt <= '0;
            {r_a, r_b, r_c} <= 3'b000;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
            r_err     <= '0;
`ifdef FIRST_FAIL_EN
            r_ff_vld  <= 1'b0;
            r_ff_vec  <= 3'b000;
`endif
          end
        end
        S_RUN: begin
          if (r_vec_cnt == VCW'(NVEC - 1)) begin
            r_state         <= S_DRAIN;
            {r_a, r_b, r_c} <= 3'b000;
          end else begin
            r_vec_cnt       <= w_vec_nxt;
            {r_a, r_b, r_c} <= w_vec_nxt[2:0];
          end
        end
        S_DRAIN: begin
          if (r_drn_cnt == DCW'(LATENCY - 1)) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            // The last compare happens on this same edge, so pass is based
            // on the count that includes it.
            r_pass  <= (w_err_nxt == '0);
          end else begin
            r_drn_cnt <= r_drn_cnt + DCW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.a_o       = r_a;
  assign bus.b_o       = r_b;
  assign bus.c_o       = r_c;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.pass      = r_pass;
  assign bus.err_count = r_err;
`ifdef FIRST_FAIL_EN
  assign bus.first_fail_vld = r_ff_vld;
  assign bus.first_fail_vec = r_ff_vec;
`endif

endmodule

// File: tb/tb_nasser_hadi_pipe_checker.sv
// ---------------------------------------------------------------------------
// tb_nasser_hadi_pipe_checker
// Directed bench for nasser_hadi_pipe_checker.
// Two checker instances share one clock and reset:
//   - default build (ERR_W=8)
//   - ERR_W=3, used for the saturation case
// Each checker drives its own model of the 2-cycle core. A mode selects
// ideal, y stuck 0, x stuck 1 or x inverted behaviour.
// Expected vectors and run results are queued when start is driven. They are
// popped and compared as the checker produces them.
// Optional feature macro: FIRST_FAIL_EN
// ---------------------------------------------------------------------------
module tb_nasser_hadi_pipe_checker;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  nasser_hadi_pipe_checker_if #(.ERR_W(8)) if8 ();
  nasser_hadi_pipe_checker_if #(.ERR_W(3)) if3 ();

  nasser_hadi_pipe_checker #(.LATENCY(2), .NUM_PASSES(4), .ERR_W(8)) u_dut8 (
    .clk (clk),
    .rst (rst),
    .bus (if8)
  );

  nasser_hadi_pipe_checker #(.LATENCY(2), .NUM_PASSES(4), .ERR_W(3)) u_dut3 (
    .clk (clk),
    .rst (rst),
    .bus (if3)
  );

  // Core models: register the inputs, then register x/y.
  // Modes: 0 ideal, 1 y stuck 0, 2 x stuck 1, 3 x inverted.
  int         mode8;
  int         mode3;
  logic [2:0] c8_p1, c3_p1;
  logic       c8_x, c8_y, c3_x, c3_y;

  always_ff @(posedge clk) begin
    c8_p1 <= {if8.a_o, if8.b_o, if8.c_o};
    c8_x  <= (c8_p1[2] & c8_p1[1]) | ~c8_p1[0];
    c8_y  <= ~c8_p1[0];
    c3_p1 <= {if3.a_o, if3.b_o, if3.c_o};
    c3_x  <= (c3_p1[2] & c3_p1[1]) | ~c3_p1[0];
    c3_y  <= ~c3_p1[0];
  end

  assign if8.x_i = (mode8 == 2) ? 1'b1 : (mode8 == 3) ? ~c8_x : c8_x;
  assign if8.y_i = (mode8 == 1) ? 1'b0 : c8_y;
  assign if3.x_i = (mode3 == 2) ? 1'b1 : (mode3 == 3) ? ~c3_x : c3_x;
  assign if3.y_i = (mode3 == 1) ? 1'b0 : c3_y;

  // Observation mux: sel=0 watches the default instance, sel=1 the ERR_W=3 one.
  bit         sel;
  logic [2:0] o_vec;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_err;
`ifdef FIRST_FAIL_EN
  logic       o_ffv;
  logic [2:0] o_ffvec;
`endif

  always_comb begin
    if (sel) begin
      o_vec  = {if3.a_o, if3.b_o, if3.c_o};
      o_busy = if3.busy;
      o_done = if3.done;
      o_pass = if3.pass;
      o_err  = {5'b00000, if3.err_count};
    end else begin
      o_vec  = {if8.a_o, if8.b_o, if8.c_o};
      o_busy = if8.busy;
      o_done = if8.done;
      o_pass = if8.pass;
      o_err  = if8.err_count;
    end
  end
`ifdef FIRST_FAIL_EN
  assign o_ffv   = sel ? if3.first_fail_vld : if8.first_fail_vld;
  assign o_ffvec = sel ? if3.first_fail_vec : if8.first_fail_vec;
`endif

  typedef struct {
    logic [7:0] err;
    logic       pass;
    logic       ffv;
    logic [2:0] ffvec;
  } res_t;

  logic [2:0] vq[$];
  res_t       rq[$];
  int         n_chk = 0;
  int         n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_start(input logic v);
    if (sel) if3.start = v;
    else     if8.start = v;
  endtask

  task automatic run_test(input string tag, input bit noise, input res_t exp);
    logic [2:0] ev;
    res_t       er;
    int         n;
    for (int k = 0; k < 32; k++) vq.push_back(3'(k));
    rq.push_back(exp);
    @(negedge clk);
    drive_start(1'b1);
    @(posedge clk);
    #1;
    drive_start(1'b0);
    for (int k = 0; k < 32; k++) begin
      ev = vq.pop_front();
      chk({tag, ".vec"}, 32'(o_vec), 32'(ev));
      chk({tag, ".busy_run"}, 32'(o_busy), 32'd1);
      if (k == 0) chk({tag, ".done_clr"}, 32'(o_done), 32'd0);
      drive_start((noise && (k == 5 || k == 31)) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
    end
    drive_start(1'b0);
    // First DRAIN cycle.
    chk({tag, ".busy_drain"}, 32'(o_busy), 32'd1);
    chk({tag, ".vec_drain"}, 32'(o_vec), 32'd0);
    if (noise) drive_start(1'b1);
    n = 0;
    while (!o_done && n < 10) begin
      @(posedge clk);
      #1;
      drive_start(1'b0);
      n++;
    end
    chk({tag, ".drain_len"}, 32'(n), 32'd2);
    er = rq.pop_front();
    chk({tag, ".busy_done"}, 32'(o_busy), 32'd0);
    chk({tag, ".err"}, 32'(o_err), 32'(er.err));
    chk({tag, ".pass"}, 32'(o_pass), 32'(er.pass));
`ifdef FIRST_FAIL_EN
    chk({tag, ".ff_vld"}, 32'(o_ffv), 32'(er.ffv));
    chk({tag, ".ff_vec"}, 32'(o_ffvec), 32'(er.ffvec));
`endif
    repeat (3) @(posedge clk);
    #1;
    chk({tag, ".done_hold"}, 32'(o_done), 32'd1);
    chk({tag, ".err_hold"}, 32'(o_err), 32'(er.err));
    chk({tag, ".vec_done"}, 32'(o_vec), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    if8.start = 1'b0;
    if3.start = 1'b0;
    mode8     = 0;
    mode3     = 3;
    sel       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.vec", 32'(o_vec), 32'd0);
    chk("rst.busy", 32'(o_busy), 32'd0);
    chk("rst.done", 32'(o_done), 32'd0);
    chk("rst.pass", 32'(o_pass), 32'd0);
    chk("rst.err", 32'(o_err), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Ideal core.
    run_test("ideal", 1'b0, '{8'd0, 1'b1, 1'b0, 3'b000});

    // y stuck 0: fails whenever C=0, four vectors per sweep.
    mode8 = 1;
    run_test("ystuck0", 1'b0, '{8'd16, 1'b0, 1'b1, 3'b000});

    // x stuck 1: fails 001, 011, 101. Restart from DONE must clear the count.
    mode8 = 2;
    run_test("xstuck1", 1'b0, '{8'd12, 1'b0, 1'b1, 3'b001});

    // start pulses during RUN/DRAIN are ignored.
    mode8 = 0;
    run_test("noise", 1'b1, '{8'd0, 1'b1, 1'b0, 3'b000});

    // Reset in cycle 10 of RUN.
    @(negedge clk);
    if8.start = 1'b1;
    @(posedge clk);
    #1;
    if8.start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    chk("midrst.vec_before", 32'(o_vec), 32'd2);
    rst = 1'b1;
    #1;
    chk("midrst.vec", 32'(o_vec), 32'd0);
    chk("midrst.busy", 32'(o_busy), 32'd0);
    chk("midrst.done", 32'(o_done), 32'd0);
    chk("midrst.pass", 32'(o_pass), 32'd0);
    chk("midrst.err", 32'(o_err), 32'd0);
`ifdef FIRST_FAIL_EN
    chk("midrst.ff_vld", 32'(o_ffv), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst.idle", 32'(o_busy), 32'd0);
    run_test("after_rst", 1'b0, '{8'd0, 1'b1, 1'b0, 3'b000});

    // ERR_W=3 with x inverted on every vector: 32 mismatches saturate at 7.
    sel = 1'b1;
    run_test("sat", 1'b0, '{8'd7, 1'b0, 1'b1, 3'b000});

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
